// File: rtl/count_event_capture_pkg.sv
// Shared types and widths for the counter event capture block.
//   EVT_*     : event type codes carried in the top two bits of a record
//   evt_rec_t : {type, count value at detection}, EVT_W bits wide
package count_evt_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned TYPE_W = 2;
  localparam int unsigned EVT_W  = 10;

  typedef enum logic [TYPE_W-1:0] {
    EVT_NONE  = 2'b00,
    EVT_MATCH = 2'b01,
    EVT_WRAP  = 2'b10,
    EVT_BOTH  = 2'b11
  } evt_type_e;

  typedef struct packed {
    evt_type_e          typ;
    logic [CNT_W-1:0]   cnt;
  } evt_rec_t;

  // Wrap occupies bit 1 and match bit 0, so both together encode EVT_BOTH.
  function automatic evt_type_e evt_classify(input logic match, input logic wrap);
    return evt_type_e'({wrap, match});
  endfunction

endpackage

// File: rtl/count_event_capture_sync_evt_fifo.sv
// Synchronous FIFO with a registered head word.
//   clk, rst_n : clock, asynchronous active-high reset
//   push, din  : write request and data (ignored when full without a pop)
//   pop        : read request (ignored when empty)
//   dout       : head record; holds the last head after the FIFO drains
//   full/empty : occupancy flags, registered
//   level      : occupancy, 0..DEPTH
module sync_evt_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop && !empty_q;
  assign push_ok = push && (!full_q || pop_ok);

  // Next pointers, level, flags and head word.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    // Head advances to the next stored entry, or takes din when the
    // queue would otherwise be empty; otherwise it holds its last value.
    if (pop_ok) begin
      if (level_q > LVL_W'(1))
        dout_d = mem_q[rd_ptr_q + PTR_W'(1)];
      else if (push_ok)
        dout_d = din;
    end else if (push_ok && empty_q) begin
      dout_d = din;
    end
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == LVL_W'(0));
  end

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = dout_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/count_event_capture.sv
// Watches an 8-bit counter for threshold-match and 0xFF->0x00 wrap events
// and queues typed records for a valid/ready consumer.
//   clk, rst_n          : clock, asynchronous active-high reset
//   count_in            : counter value, sampled every cycle
//   thr_we, thr_data    : threshold write (takes effect next cycle)
//   evt_valid/ready     : record handshake; evt_data = {type[1:0], count[7:0]}
//   fifo_level          : queue occupancy
//   ovf, ovf_clr        : sticky drop flag and its clear (a drop wins)
//   drop_cnt            : saturating drop count, only with CAPTURE_DROP_CNT_EN
module count_event_capture
  import count_evt_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  THR_RESET = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CNT_W-1:0]         count_in,
  input  logic                     thr_we,
  input  logic [CNT_W-1:0]         thr_data,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [EVT_W-1:0]         evt_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef CAPTURE_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] prev_q;
  logic             prev_vld_q;
  logic             ovf_q, ovf_d;
  logic             match, wrap, evt_any, drop;
  logic             fifo_full, fifo_empty, pop, push;
  evt_type_e        evt_type;
  evt_rec_t         rec;

  // Match fires only on entry into equality; wrap needs a valid previous sample.
  assign match    = (count_in == thr_q) && (!prev_vld_q || (prev_q != thr_q));
  assign wrap     = prev_vld_q && (prev_q == 8'hFF) && (count_in == 8'h00);
  assign evt_type = evt_classify(match, wrap);
  assign evt_any  = (evt_type != EVT_NONE);
  assign rec      = '{typ: evt_type, cnt: count_in};

  assign pop  = !fifo_empty && evt_ready;
  assign push = evt_any && (!fifo_full || pop);
  assign drop = evt_any && fifo_full && !pop;

  // Threshold and sticky overflow next-state; a drop beats a clear.
  always_comb begin
    thr_d = thr_q;
    ovf_d = ovf_q;
    if (thr_we) thr_d = thr_data;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      thr_q      <= THR_RESET;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      thr_q      <= thr_d;
      prev_q     <= count_in;
      prev_vld_q <= 1'b1;
      ovf_q      <= ovf_d;
    end
  end

  sync_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (rec),
    .dout  (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign evt_valid = !fifo_empty;
  assign ovf       = ovf_q;

`ifdef CAPTURE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; a drop coinciding with a clear restarts at 1.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (ovf_clr)                  drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  // Drop counting is not built; overflow is reported through ovf alone.
`endif

endmodule

// File: tb/tb_count_event_capture.sv
module tb_count_event_capture;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] count_in;
  logic       thr_we;
  logic [7:0] thr_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [9:0] evt_data;
  logic [2:0] fifo_level;
  logic       ovf;
  logic       ovf_clr;
`ifdef CAPTURE_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  count_event_capture #(.DEPTH(DEPTH), .THR_RESET(8'hFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_in   (count_in),
    .thr_we     (thr_we),
    .thr_data   (thr_data),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
`ifdef CAPTURE_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference: a queue of records plus the detection rules.
  logic [9:0] m_q[$];
  logic [7:0] m_thr, m_prev;
  logic       m_pv, m_ovf;
  logic [9:0] m_last;
  int         m_dcnt;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_thr = 8'hFF; m_prev = 8'h00; m_pv = 1'b0;
    m_ovf = 1'b0; m_last = 10'h0; m_dcnt = 0;
  endfunction

  function automatic void m_update(input logic [7:0] cin, input logic we, input logic [7:0] td,
                                   input logic rdy, input logic clr);
    bit is_match, is_wrap, ev, pop, drop;
    is_match = (cin == m_thr) && !(m_pv && m_prev == m_thr);
    is_wrap  = m_pv && m_prev == 8'hFF && cin == 8'h00;
    ev   = is_match || is_wrap;
    pop  = (m_q.size() > 0) && rdy;
    drop = ev && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (ev && !drop) m_q.push_back({is_wrap, is_match, cin});
    if (drop) begin
      m_ovf = 1'b1;
      m_dcnt = clr ? 1 : (m_dcnt < 255 ? m_dcnt + 1 : 255);
    end else if (clr) begin
      m_ovf = 1'b0;
      m_dcnt = 0;
    end
    if (we) m_thr = td;
    m_prev = cin; m_pv = 1'b1;
    if (m_q.size() > 0) m_last = m_q[0];
  endfunction

  task automatic cmp_model();
    chk("valid", int'(evt_valid), int'(m_q.size() != 0));
    chk("level", int'(fifo_level), m_q.size());
    chk("data", int'(evt_data), int'(m_last));
    chk("ovf", int'(ovf), int'(m_ovf));
`ifdef CAPTURE_DROP_CNT_EN
    chk("drop_cnt", int'(drop_cnt), m_dcnt);
`endif
  endtask

  // One cycle: drive at negedge, advance model, clock, compare at next negedge.
  task automatic step(input logic [7:0] cin, input logic we = 1'b0, input logic [7:0] td = 8'h00,
                      input logic rdy = 1'b0, input logic clr = 1'b0);
    count_in = cin; thr_we = we; thr_data = td; evt_ready = rdy; ovf_clr = clr;
    m_update(cin, we, td, rdy, clr);
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  typedef struct {
    logic [7:0] cin;
    logic       we;
    logic [7:0] td;
    logic       rdy;
    logic       e_valid;
    logic [9:0] e_data;
    int         e_level;
  } vec_t;

  vec_t       tbl[12];
  logic [9:0] seen[$];
  logic [9:0] exp_rec[4];

  initial begin
    rst_n = 1'b1; count_in = 8'h00; thr_we = 1'b0; thr_data = 8'h00;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    m_reset();

    // thr=0 double event, then thr=0x10 held for five cycles.
    tbl[0]  = '{8'h50, 1'b1, 8'h00, 1'b1, 1'b0, 10'h000, 0};
    tbl[1]  = '{8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 10'h000, 0};
    tbl[2]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 10'h300, 1};
    tbl[3]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 10'h300, 0};
    tbl[4]  = '{8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 10'h300, 0};
    tbl[5]  = '{8'h0F, 1'b1, 8'h10, 1'b0, 1'b0, 10'h300, 0};
    tbl[6]  = '{8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 10'h110, 1};
    tbl[7]  = '{8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 10'h110, 1};
    tbl[8]  = '{8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 10'h110, 1};
    tbl[9]  = '{8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 10'h110, 1};
    tbl[10] = '{8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 10'h110, 1};
    tbl[11] = '{8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 10'h110, 0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_data", int'(evt_data), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].cin, tbl[i].we, tbl[i].td, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), int'(evt_valid), int'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i), int'(evt_data), int'(tbl[i].e_data));
      chk($sformatf("tbl%0d_level", i), int'(fifo_level), tbl[i].e_level);
    end

    // Full sweep with thr=0x10: exactly one match and one wrap record.
    for (int v = 0; v <= 256; v++) begin
      step(8'(v), 1'b0, 8'h00, 1'b1);
      if (evt_valid) seen.push_back(evt_data);
    end
    step(8'h20, 1'b0, 8'h00, 1'b1);
    chk("sweep_count", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("sweep_rec0", int'(seen[0]), 'h110);
      chk("sweep_rec1", int'(seen[1]), 'h200);
    end

    // Five events with the consumer stalled: fifth is dropped.
    step(8'h10); step(8'hFF); step(8'h00); step(8'h10);
    step(8'hFF); step(8'h00); step(8'h10);
    chk("ovf_level", int'(fifo_level), 4);
    chk("ovf_flag", int'(ovf), 1);
`ifdef CAPTURE_DROP_CNT_EN
    chk("ovf_dropcnt", int'(drop_cnt), 1);
`endif
    exp_rec[0] = 10'h110; exp_rec[1] = 10'h200; exp_rec[2] = 10'h110; exp_rec[3] = 10'h200;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), int'(evt_valid), 1);
      chk($sformatf("drain%0d_data", i), int'(evt_data), int'(exp_rec[i]));
      step(8'h20, 1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", int'(evt_valid), 0);
    step(8'h20, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", int'(ovf), 0);

    // Full FIFO with an event arriving while the consumer pops.
    step(8'h10); step(8'h20); step(8'h10); step(8'h20);
    step(8'h10); step(8'h20); step(8'h10); step(8'h20);
    chk("full_level", int'(fifo_level), 4);
    step(8'h10, 1'b0, 8'h00, 1'b1);
    chk("fullpop_level", int'(fifo_level), 4);
    chk("fullpop_ovf", int'(ovf), 0);
    for (int i = 0; i < 5; i++) step(8'h20, 1'b0, 8'h00, 1'b1);
    chk("fullpop_drained", int'(fifo_level), 0);

    // Threshold write coinciding with the new value on count_in.
    step(8'h20, 1'b1, 8'hFF, 1'b1);
    step(8'h05, 1'b1, 8'h05, 1'b1);
    chk("thrw_same_cycle", int'(evt_valid), 0);
    step(8'h05, 1'b0, 8'h00, 1'b1);
    chk("thrw_held", int'(evt_valid), 0);
    step(8'h06, 1'b0, 8'h00, 1'b1);
    step(8'h05, 1'b0, 8'h00, 1'b0);
    chk("thrw_repass_valid", int'(evt_valid), 1);
    chk("thrw_repass_data", int'(evt_data), 'h105);
    step(8'h06, 1'b0, 8'h00, 1'b1);

    // Reset asserted mid-drain with three records queued.
    step(8'h05); step(8'h06); step(8'h05); step(8'h06); step(8'h05);
    chk("mid_level", int'(fifo_level), 3);
    evt_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("async_valid", int'(evt_valid), 0);
    chk("async_level", int'(fifo_level), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    m_reset();
    step(8'hFF, 1'b0, 8'h00, 1'b0);
    chk("post_rst_match", int'(evt_data), 'h1FF);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] c;
      case ($urandom_range(0, 5))
        0: c = 8'h00;
        1: c = 8'hFF;
        2: c = m_thr;
        3: c = m_prev;
        default: c = 8'($urandom_range(0, 255));
      endcase
      step(c, ($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
